// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divider: op codes, FSM states and latched op control.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  typedef struct packed {
    logic is_rem;
    logic neg_quo;
    logic neg_rem;
  } div_ctl_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // shifted is one bit wider so the trial borrow lands in the MSB
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring division at one bit per cycle, with
// single-cycle fast path for divide-by-zero and signed overflow.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  div_state_e      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  div_ctl_t        ctl_q;

  div_op_e         op_e;
  logic            is_signed, is_rem, rs1_neg, rs2_neg, div0, ovf, fast;
  logic [XLEN-1:0] abs1, abs2, fast_res;
  logic [XLEN-1:0] rem_nx, quo_nx, fin_res;

  // accept-time decode of the incoming operands
  always_comb begin
    op_e      = div_op_e'(op);
    is_signed = (op_e == DIV_OP_DIV) || (op_e == DIV_OP_REM);
    is_rem    = (op_e == DIV_OP_REM) || (op_e == DIV_OP_REMU);
    rs1_neg   = is_signed && rs1[XLEN-1];
    rs2_neg   = is_signed && rs2[XLEN-1];
    abs1      = rs1_neg ? negate(rs1) : rs1;
    abs2      = rs2_neg ? negate(rs2) : rs2;
    div0      = (rs2 == '0);
    ovf       = is_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
    fast      = div0 || ovf;
    fast_res  = '0;
    if (div0)     fast_res = is_rem ? rs1 : '1;
    else if (ovf) fast_res = is_rem ? '0 : rs1;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // sign fix-up applied to the final iteration's outputs
  always_comb begin
    if (ctl_q.is_rem) fin_res = ctl_q.neg_rem ? negate(rem_nx) : rem_nx;
    else              fin_res = ctl_q.neg_quo ? negate(quo_nx) : quo_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= DIV_IDLE;
      count  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      ctl_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start && !kill) begin
            ctl_q.is_rem  <= is_rem;
            ctl_q.neg_quo <= rs1_neg ^ rs2_neg;
            ctl_q.neg_rem <= rs1_neg;
            busy          <= 1'b1;
            if (fast) begin
              state  <= DIV_DONE;
              done   <= 1'b1;
              result <= fast_res;
            end else begin
              state <= DIV_CALC;
              count <= '0;
              rem_q <= '0;
              quo_q <= abs1;
              dvs_q <= abs2;
            end
          end
        end
        DIV_CALC: begin
          if (kill) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            count <= count + CW'(1);
            if (count == CW'(XLEN - 1)) begin
              state  <= DIV_DONE;
              done   <= 1'b1;
              result <= fin_res;
            end
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver queues expected result and done cycle,
// a negedge monitor pops and checks on every done pulse.
module tb_div_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic            clk = 1'b0;
  logic            reset, start, kill;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic            busy, done;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  exp_t            sbq[$];
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  int              done_cnt = 0;
  logic [XLEN-1:0] last_res = '0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("timeout", 32'(sbq.size()), 32'(0));
  endtask

  task automatic apply(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit is_fast);
    apply(o, a, b);
    sbq.push_back('{exp, cyc + (is_fast ? 0 : int'(XLEN))});
    last_res = exp;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_result", result, 32'h0);
    reset = 1'b0;

    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    issue(OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0);
    issue(OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b0);
    issue(OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 1'b0);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'h1999_9999, 1'b0);
    issue(OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0);
    issue(OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0);
    issue(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);

    // kill in the middle of CALC: no done, result untouched
    apply(OP_DIVU, 32'd1000, 32'd3);
    chk("busy_after_accept", 32'(busy), 32'(1));
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", 32'(busy), 32'(0));
    chk("kill_result_held", result, last_res);
    repeat (40) @(negedge clk);
    chk("kill_no_done", 32'(done), 32'(0));
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0);

    // start & kill together: nothing accepted
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd3;
    @(posedge clk);
    #1 begin start = 1'b0; kill = 1'b0; end
    @(negedge clk);
    chk("startkill_busy", 32'(busy), 32'(0));
    chk("startkill_result", result, last_res);

    // start held through the operation yields a single done
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs1 = 32'd50; rs2 = 32'd5;
    @(posedge clk);
    #1 sbq.push_back('{32'd10, cyc + int'(XLEN)});
    last_res = 32'd10;
    repeat (19) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("held_start_one_done", 32'(done_cnt - d0), 32'(1));

    // reset mid-operation clears everything immediately
    apply(OP_DIVU, 32'd1000, 32'd7);
    repeat (15) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 32'(0));
    chk("midreset_done", 32'(done), 32'(0));
    chk("midreset_result", result, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_idle", 32'(busy), 32'(0));
    issue(OP_REMU, 32'd1000, 32'd7, 32'd6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
